lsu_mem_arbiter: RTL and testbench
==================================

LSU_MEM_ARBITER -- requirements
Module: lsu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8: memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4: number of LSU requesters, one per thread of a warp.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have ports consumer_read_valid / consumer_read_address  input  NUM_CONSUMERS / NUM_CONSUMERS*ADDR_BITS  per-LSU read requests.
REQ-007 SHALL have ports consumer_read_ready / consumer_read_data  output  NUM_CONSUMERS / NUM_CONSUMERS*DATA_BITS  per-LSU read completion and data.
REQ-008 SHALL have ports consumer_write_valid / consumer_write_address / consumer_write_data  input  NUM_CONSUMERS / NUM_CONSUMERS*ADDR_BITS / NUM_CONSUMERS*DATA_BITS  per-LSU write requests.
REQ-009 SHALL have port consumer_write_ready  output  NUM_CONSUMERS  per-LSU write completion.
REQ-010 SHALL have ports mem_read_valid, mem_read_address, mem_read_ready (input), mem_read_data (input)  1/ADDR_BITS/1/DATA_BITS  data-memory read channel.
REQ-011 SHALL have ports mem_write_valid, mem_write_address, mem_write_data, mem_write_ready (input)  1/ADDR_BITS/DATA_BITS/1  data-memory write channel.

Function
REQ-012 SHALL implement FSM states IDLE, READ_WAITING, WRITE_WAITING, RELAYING.
REQ-013 IDLE: SHALL select one consumer with read_valid or write_valid set; if none, stay IDLE with all outputs low.
REQ-014 Same consumer with both read_valid and write_valid: read SHALL be served first; the write is taken on a later grant.
REQ-015 On grant, the next cycle SHALL drive mem_read_valid=1 with the latched address (READ_WAITING) or mem_write_valid=1 with the latched address/data (WRITE_WAITING); request-to-memory latency exactly 1 cycle.
REQ-016 Address/data SHALL be latched at grant; later consumer input changes SHALL NOT affect the active transaction.
REQ-017 In WAITING, on the cycle mem_*_ready=1 the FSM SHALL capture mem_read_data (reads), deassert mem_*_valid next cycle, and go to RELAYING.
REQ-018 RELAYING: SHALL hold consumer_read_ready (with data) or consumer_write_ready high for the granted consumer only, until that consumer's corresponding valid is low, then drop ready and return to IDLE in the same edge.
REQ-019 At most one consumer ready bit SHALL be high at any time; mem_read_valid and mem_write_valid SHALL never be high together.
REQ-020 Grant SHALL be arbitrated per REQ-025/REQ-026; an index that wraps past NUM_CONSUMERS-1 SHALL return to 0.
REQ-021 A memory ready arriving while not in the matching WAITING state SHALL be ignored.

Reset
REQ-022 reset=0 SHALL immediately force state IDLE, all valid/ready outputs 0, address/data outputs 0, arbitration pointer 0.
REQ-023 Reset during any state SHALL abandon the transaction; no consumer ready SHALL be issued for it after release.
REQ-024 First grant after reset release SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-025 With LSU_ARB_ROUND_ROBIN_EN defined: search starts at pointer; after each completed transaction the pointer SHALL become granted index+1 (mod NUM_CONSUMERS).
REQ-026 Without LSU_ARB_ROUND_ROBIN_EN: fixed priority, lowest-index requesting consumer SHALL win; no pointer state.

Verification
REQ-027 Consumer 2 reads addr 0x10, memory returns 0x5A with ready 3 cycles later -> mem_read_valid one cycle after request, consumer_read_ready[2]=1 with data 0x5A, others 0.
REQ-028 Consumer 1 writes 0x33 to 0x20 -> mem_write_valid with addr 0x20/data 0x33; consumer_write_ready[1] held until write_valid[1] drops, then IDLE.
REQ-029 All 4 consumers read simultaneously (RR enabled) -> served in order 0,1,2,3; then new request from 0 and 3 with pointer=0 -> 0 first.
REQ-030 Same all-4 case, macro undefined, consumer 0 re-requesting immediately -> consumer 0 served twice before 1.
REQ-031 Reset asserted in READ_WAITING, mem ready pulses after release -> no consumer ready, mem_read_valid 0, FSM IDLE.
REQ-032 Consumer 3 asserts read and write together -> read completes first, write follows on next grant to 3.

Source files
------------

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: arbitrates per-thread LSU read/write requests onto a single data-memory port.
// Define LSU_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed lowest-index priority.
module lsu_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);
    localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAITING, WRITE_WAITING, RELAYING} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            sel_q, sel_d, pick;
    logic                     wr_q, wr_d, found;
    logic [ADDR_BITS-1:0]     addr_q, addr_d;
    logic [DATA_BITS-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_CONSUMERS-1:0] req;
    int                       idx;
`ifdef LSU_ARB_ROUND_ROBIN_EN
    logic [IW-1:0]            ptr_q, ptr_d;
`endif

    assign req = consumer_read_valid | consumer_write_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef LSU_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        found   = 1'b0;
        pick    = '0;
        idx     = 0;
`ifdef LSU_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
`ifdef LSU_ARB_ROUND_ROBIN_EN
            idx = (i + int'(ptr_q)) % NUM_CONSUMERS;
`else
            idx = i;
`endif
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
        case (state_q)
            IDLE: if (found) begin
                // a consumer with both requests pending gets its read first
                sel_d   = pick;
                wr_d    = !consumer_read_valid[pick];
                addr_d  = wr_d ? consumer_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS]
                               : consumer_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
                wdata_d = consumer_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
                state_d = wr_d ? WRITE_WAITING : READ_WAITING;
            end
            READ_WAITING: if (mem_read_ready) begin
                rdata_d = mem_read_data;
                state_d = RELAYING;
            end
            WRITE_WAITING: if (mem_write_ready) state_d = RELAYING;
            default: if (!(wr_q ? consumer_write_valid[sel_q] : consumer_read_valid[sel_q])) begin
                state_d = IDLE;
`ifdef LSU_ARB_ROUND_ROBIN_EN
                ptr_d   = (int'(sel_q) == NUM_CONSUMERS - 1) ? '0 : sel_q + 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        mem_read_valid       = state_q == READ_WAITING;
        mem_write_valid      = state_q == WRITE_WAITING;
        mem_read_address     = mem_read_valid ? addr_q : '0;
        mem_write_address    = mem_write_valid ? addr_q : '0;
        mem_write_data       = mem_write_valid ? wdata_q : '0;
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        consumer_read_data   = '0;
        if (state_q == RELAYING) begin
            if (wr_q) begin
                consumer_write_ready[sel_q] = 1'b1;
            end else begin
                consumer_read_ready[sel_q] = 1'b1;
                consumer_read_data[int'(sel_q)*DATA_BITS +: DATA_BITS] = rdata_q;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb_lsu_mem_arbiter: directed self-checking bench for lsu_mem_arbiter (4 consumers, 8-bit address/data).
module tb_lsu_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  crv = '0, cwv = '0, crr, cwr;
    logic [31:0] cra = '0, cwa = '0, cwd = '0, crd;
    logic        mrv, mrr = 1'b0, mwv, mwr = 1'b0;
    logic [7:0]  mra, mrd = '0, mwa, mwd;
    int          checks = 0;
    int          errors = 0;

    lsu_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4)) dut (
        .clk(clk),
        .reset(reset),
        .consumer_read_valid(crv),
        .consumer_read_address(cra),
        .consumer_read_ready(crr),
        .consumer_read_data(crd),
        .consumer_write_valid(cwv),
        .consumer_write_address(cwa),
        .consumer_write_data(cwd),
        .consumer_write_ready(cwr),
        .mem_read_valid(mrv),
        .mem_read_address(mra),
        .mem_read_ready(mrr),
        .mem_read_data(mrd),
        .mem_write_valid(mwv),
        .mem_write_address(mwa),
        .mem_write_data(mwd),
        .mem_write_ready(mwr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_outs"}, {crr, cwr, mrv, mwv, mra, mwa, mwd}, '0);
        check({tag, "_crd"}, crd, '0);
    endtask

    task automatic serve(input int e, input bit rereq, input string tag);
        tick();
        check({tag, "_addr"}, {mrv, mra}, {1'b1, 8'h40 + 8'(e)});
        mrr = 1'b1;
        mrd = 8'hA0 + 8'(e);
        tick();
        mrr = 1'b0;
        mrd = 8'h00;
        check({tag, "_rdy"}, crr, 4'b0001 << e);
        check({tag, "_data"}, crd, 32'(8'hA0 + 8'(e)) << (8 * e));
        crv[e] = 1'b0;
        tick();
        if (rereq) crv[e] = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        check_idle("reset");
        reset = 1'b1;
        tick();
        check_idle("post_reset");

        crv[2] = 1'b1;
        cra[23:16] = 8'h10;
        tick();
        check("a_req", {mrv, mwv, mra, crr}, {1'b1, 1'b0, 8'h10, 4'b0000});
        cra[23:16] = 8'h77;
        tick();
        tick();
        check("a_latched", {mrv, mra}, {1'b1, 8'h10});
        mrr = 1'b1;
        mrd = 8'h5A;
        tick();
        mrr = 1'b0;
        mrd = 8'hFF;
        check("a_relay", {mrv, crr, cwr}, {1'b0, 4'b0100, 4'b0000});
        check("a_data", crd, 32'h005A0000);
        tick();
        check("a_hold", crr, 4'b0100);
        crv[2] = 1'b0;
        tick();
        check_idle("a_done");

        cwv[1] = 1'b1;
        cwa[15:8] = 8'h20;
        cwd[15:8] = 8'h33;
        tick();
        check("b_req", {mwv, mrv, mwa, mwd}, {1'b1, 1'b0, 8'h20, 8'h33});
        mrr = 1'b1;
        tick();
        mrr = 1'b0;
        check("b_ignore_rd", {mwv, mrv, crr, cwr}, {1'b1, 1'b0, 4'b0000, 4'b0000});
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        check("b_relay", {mwv, cwr, crr}, {1'b0, 4'b0010, 4'b0000});
        tick();
        check("b_hold", cwr, 4'b0010);
        cwv[1] = 1'b0;
        tick();
        check_idle("b_done");

        crv[3] = 1'b1;
        cwv[3] = 1'b1;
        cra[31:24] = 8'h30;
        cwa[31:24] = 8'h31;
        cwd[31:24] = 8'h99;
        tick();
        check("e_read_first", {mrv, mwv, mra}, {1'b1, 1'b0, 8'h30});
        mrr = 1'b1;
        mrd = 8'h42;
        tick();
        mrr = 1'b0;
        check("e_read_rdy", {crr, cwr, crd}, {4'b1000, 4'b0000, 32'h42000000});
        crv[3] = 1'b0;
        tick();
        check_idle("e_between");
        tick();
        check("e_write", {mwv, mrv, mwa, mwd}, {1'b1, 1'b0, 8'h31, 8'h99});
        mwr = 1'b1;
        tick();
        mwr = 1'b0;
        check("e_write_rdy", {cwr, crr}, {4'b1000, 4'b0000});
        cwv[3] = 1'b0;
        tick();
        check_idle("e_done");

        crv[1] = 1'b1;
        cra[15:8] = 8'h55;
        tick();
        check("d_wait", {mrv, mra}, {1'b1, 8'h55});
        #1 reset = 1'b0;
        #1 check_idle("d_async_reset");
        crv[1] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        mrr = 1'b1;
        mrd = 8'hEE;
        tick();
        tick();
        mrr = 1'b0;
        check_idle("d_after_release");

        for (int i = 0; i < 4; i++) cra[i*8 +: 8] = 8'h40 + 8'(i);
        crv = 4'b1111;
`ifdef LSU_ARB_ROUND_ROBIN_EN
        serve(0, 1'b1, "c0");
        serve(1, 1'b0, "c1");
        serve(2, 1'b0, "c2");
        serve(3, 1'b0, "c3");
        serve(0, 1'b0, "c4");
`else
        serve(0, 1'b1, "c0");
        serve(0, 1'b0, "c1");
        serve(1, 1'b0, "c2");
        serve(2, 1'b0, "c3");
        serve(3, 1'b0, "c4");
`endif
        check_idle("c_done");

        crv = 4'b1001;
`ifdef LSU_ARB_ROUND_ROBIN_EN
        serve(3, 1'b0, "f0");
        serve(0, 1'b0, "f1");
`else
        serve(0, 1'b0, "f0");
        serve(3, 1'b0, "f1");
`endif
        check_idle("f_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
